// File: rtl/micro_tile_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : micro_tile_scheduler
// Description : Time-shares one 8-bit input bank and one 8-bit output bank
//               among N_TILES micro tiles. Auto mode rotates round-robin
//               over the enabled tiles with fixed-length slots; manual mode
//               gives the pins to a host-selected tile. Inputs to idle tiles
//               are forced to zero, the owning tile's output is registered,
//               and every slot change inserts a one-cycle guard.
// Ports       : clk, rst       - clock (rising edge), async active-high reset
//               mode           - 0 = auto round-robin, 1 = manual
//               sel_in         - manual tile select
//               en_mask        - per-tile enable
//               ui_in          - shared input pins
//               tile_uo        - tile outputs, tile k at [8k+7:8k]
//               tile_ui        - per-tile inputs (gated copy of ui_in)
//               uo_out         - shared output pins, registered
//               cur_sel        - tile currently owning the pins
//               tile_ena       - one-hot active-tile strobe, zero when idle
//               slot_start     - pulse in the first RUN cycle of each slot
// Revision    : 1.0 - initial release
// ============================================================================
module micro_tile_scheduler #(
    parameter int N_TILES     = 4,
    parameter int SELW        = 2,
    parameter int SLOT_CYCLES = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 mode,
    input  logic [SELW-1:0]      sel_in,
    input  logic [N_TILES-1:0]   en_mask,
    input  logic [7:0]           ui_in,
    input  logic [N_TILES*8-1:0] tile_uo,
    output logic [N_TILES*8-1:0] tile_ui,
    output logic [7:0]           uo_out,
    output logic [SELW-1:0]      cur_sel,
    output logic [N_TILES-1:0]   tile_ena,
    output logic                 slot_start
);

    localparam int c_cntw = (SLOT_CYCLES > 1) ? $clog2(SLOT_CYCLES) : 1;
    localparam logic [c_cntw-1:0] c_cnt_last = c_cntw'(SLOT_CYCLES - 1);

    localparam logic [1:0] c_st_idle   = 2'd0;
    localparam logic [1:0] c_st_switch = 2'd1;
    localparam logic [1:0] c_st_run    = 2'd2;

    logic [1:0]         r_state;
    logic [SELW-1:0]    r_cur_sel;
    logic [SELW-1:0]    r_next;
    logic [c_cntw-1:0]  r_cnt;
    logic [7:0]         r_uo;
    logic [N_TILES-1:0] r_ena;
    logic               r_slot_start;

    logic [7:0]         w_cur_uo;
    logic               w_cur_en;
    logic               w_any_en;
    logic               w_sel_ok;
    logic               w_expire;
    logic               w_manual_hop;
    logic               w_end_slot;
    logic [SELW-1:0]    w_idle_next;
    logic [SELW-1:0]    w_sw_next;
    logic [SELW-1:0]    w_run_next;

    // True when sel names an existing tile whose enable bit is set. An
    // out-of-range select never matches any k, so it is rejected for free.
    function automatic logic f_sel_ok(input logic [SELW-1:0] sel,
                                      input logic [N_TILES-1:0] mask);
        logic ok;
        ok = 1'b0;
        for (int k = 0; k < N_TILES; k++) begin
            if (sel == SELW'(k) && mask[k]) begin
                ok = 1'b1;
            end
        end
        return ok;
    endfunction

    // First enabled tile after cur, searching cur+1 upward with wrap-around.
    // cur itself is examined last, so a lone enabled tile reselects itself.
    function automatic logic [SELW-1:0] f_rr_next(input logic [SELW-1:0] cur,
                                                  input logic [N_TILES-1:0] mask);
        logic [SELW-1:0] res;
        logic            found;
        int              idx;
        res   = cur;
        found = 1'b0;
        for (int i = 1; i <= N_TILES; i++) begin
            idx = (int'(cur) + i) % N_TILES;
            for (int k = 0; k < N_TILES; k++) begin
                if (!found && k == idx && mask[k]) begin
                    res   = SELW'(k);
                    found = 1'b1;
                end
            end
        end
        return res;
    endfunction

    function automatic logic [N_TILES-1:0] f_onehot(input logic [SELW-1:0] idx);
        logic [N_TILES-1:0] oh;
        oh = '0;
        for (int k = 0; k < N_TILES; k++) begin
            oh[k] = (idx == SELW'(k));
        end
        return oh;
    endfunction

    always_comb begin
        w_cur_uo = 8'h00;
        w_cur_en = 1'b0;
        for (int k = 0; k < N_TILES; k++) begin
            if (r_cur_sel == SELW'(k)) begin
                w_cur_uo = tile_uo[8*k +: 8];
                w_cur_en = en_mask[k];
            end
        end
    end

    assign w_any_en = |en_mask;
    assign w_sel_ok = f_sel_ok(sel_in, en_mask);

    // Auto start from IDLE: search from index 0, i.e. "after" the last tile.
    assign w_idle_next = (mode && w_sel_ok) ? sel_in
                                            : f_rr_next(SELW'(N_TILES - 1), en_mask);

    // The tile picked on entry to SWITCH may have been disabled during the
    // guard cycle; fall back to the next enabled one so it is never granted.
    assign w_sw_next = f_sel_ok(r_next, en_mask) ? r_next : f_rr_next(r_next, en_mask);

    assign w_expire     = !mode && (r_cnt == c_cnt_last);
    assign w_manual_hop = mode && w_sel_ok && (sel_in != r_cur_sel);

    // Expiry, self-disable and manual hop collapse into a single SWITCH.
    assign w_end_slot = !w_cur_en || w_expire || w_manual_hop;
    assign w_run_next = (mode && w_sel_ok) ? sel_in : f_rr_next(r_cur_sel, en_mask);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= c_st_idle;
            r_cur_sel    <= '0;
            r_next       <= '0;
            r_cnt        <= '0;
            r_uo         <= 8'h00;
            r_ena        <= '0;
            r_slot_start <= 1'b0;
        end else begin
            r_slot_start <= 1'b0;
            case (r_state)
                c_st_idle: begin
                    r_uo  <= 8'h00;
                    r_ena <= '0;
                    if (w_any_en) begin
                        r_state <= c_st_switch;
                        r_next  <= w_idle_next;
                    end
                end
                c_st_switch: begin
                    if (!w_any_en) begin
                        r_state <= c_st_idle;
                    end else begin
                        r_state      <= c_st_run;
                        r_cur_sel    <= w_sw_next;
                        r_cnt        <= '0;
                        r_ena        <= f_onehot(w_sw_next);
                        r_slot_start <= 1'b1;
                    end
                end
                c_st_run: begin
                    r_uo <= w_cur_uo;
                    if (!w_any_en) begin
                        r_state <= c_st_idle;
                        r_ena   <= '0;
                    end else if (w_end_slot) begin
                        r_state <= c_st_switch;
                        r_ena   <= '0;
                        r_next  <= w_run_next;
                    end else if (!mode) begin
                        // Manual mode freezes the counter so auto resumes
                        // from the same point.
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                default: begin
                    r_state <= c_st_idle;
                    r_ena   <= '0;
                end
            endcase
        end
    end

    for (genvar k = 0; k < N_TILES; k++) begin : g_tile_ui
        assign tile_ui[8*k +: 8] = r_ena[k] ? ui_in : 8'h00;
    end

    assign uo_out     = r_uo;
    assign cur_sel    = r_cur_sel;
    assign tile_ena   = r_ena;
    assign slot_start = r_slot_start;

endmodule
`default_nettype wire

// File: tb/tb_micro_tile_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : tb_micro_tile_scheduler
// Description : Self-checking bench for micro_tile_scheduler (N_TILES=4,
//               SLOT_CYCLES=4). A vector table drives the auto round-robin
//               sequence with a uo_out scoreboard; hand-written sequences
//               cover datapath gating, disables, manual mode and reset.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_micro_tile_scheduler;

    localparam int c_n    = 4;
    localparam int c_selw = 2;
    localparam int c_slot = 4;

    logic                 clk = 1'b0;
    logic                 rst;
    logic                 mode;
    logic [c_selw-1:0]    sel_in;
    logic [c_n-1:0]       en_mask;
    logic [7:0]           ui_in;
    logic [c_n*8-1:0]     tile_uo;
    logic [c_n*8-1:0]     tile_ui;
    logic [7:0]           uo_out;
    logic [c_selw-1:0]    cur_sel;
    logic [c_n-1:0]       tile_ena;
    logic                 slot_start;

    micro_tile_scheduler #(
        .N_TILES     (c_n),
        .SELW        (c_selw),
        .SLOT_CYCLES (c_slot)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .mode       (mode),
        .sel_in     (sel_in),
        .en_mask    (en_mask),
        .ui_in      (ui_in),
        .tile_uo    (tile_uo),
        .tile_ui    (tile_ui),
        .uo_out     (uo_out),
        .cur_sel    (cur_sel),
        .tile_ena   (tile_ena),
        .slot_start (slot_start)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] mask;
        logic [3:0] exp_ena;
        logic       exp_ss;
    } vec_t;

    vec_t       tv [20];
    logic [7:0] sb_q [$];
    int         checks   = 0;
    int         failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic sb_check(input string name);
        logic [7:0] e;
        if (sb_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL %s: scoreboard empty, got 0x%0h", name, uo_out);
        end else begin
            e = sb_q.pop_front();
            chk(name, {24'h0, uo_out}, {24'h0, e});
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic int oh_idx(input logic [3:0] oh);
        int r;
        r = 0;
        for (int k = 0; k < 4; k++) begin
            if (oh[k]) r = k;
        end
        return r;
    endfunction

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [3:0] prev_ena;
        logic [7:0] model_uo;
        logic [3:0] slot_ena [4];
        int         t;

        rst     = 1'b1;
        mode    = 1'b0;
        sel_in  = '0;
        en_mask = '0;
        ui_in   = 8'h00;
        tile_uo = '0;

        // Auto rotation over 1011: tiles 0,1,3,0, each slot = guard + 4 RUN.
        slot_ena[0] = 4'b0001;
        slot_ena[1] = 4'b0010;
        slot_ena[2] = 4'b1000;
        slot_ena[3] = 4'b0001;
        for (int s = 0; s < 4; s++) begin
            tv[5*s] = '{4'b1011, 4'b0000, 1'b0};
            for (int c = 0; c < 4; c++) begin
                tv[5*s+1+c] = '{4'b1011, slot_ena[s], (c == 0)};
            end
        end

        // ---------------- reset state ----------------
        step();
        step();
        chk("rst_tile_ena", {28'h0, tile_ena}, 32'h0);
        chk("rst_uo_out", {24'h0, uo_out}, 32'h0);
        chk("rst_cur_sel", {30'h0, cur_sel}, 32'h0);
        chk("rst_slot_start", {31'h0, slot_start}, 32'h0);
        #2 rst = 1'b0;
        step();
        step();
        step();
        chk("idle_tile_ena", {28'h0, tile_ena}, 32'h0);
        chk("idle_uo_out", {24'h0, uo_out}, 32'h0);

        // ---------------- table-driven round-robin ----------------
        prev_ena = 4'b0000;
        model_uo = 8'h00;
        for (int i = 0; i < 20; i++) begin
            en_mask = tv[i].mask;
            tile_uo = $urandom();
            // A RUN cycle captures the owner's output; a guard cycle holds.
            if (prev_ena != 4'b0000) begin
                t        = oh_idx(prev_ena);
                model_uo = tile_uo[8*t +: 8];
            end
            sb_q.push_back(model_uo);
            step();
            chk($sformatf("rr_ena[%0d]", i), {28'h0, tile_ena}, {28'h0, tv[i].exp_ena});
            chk($sformatf("rr_ss[%0d]", i), {31'h0, slot_start}, {31'h0, tv[i].exp_ss});
            if (tv[i].exp_ena != 4'b0000) begin
                chk($sformatf("rr_sel[%0d]", i), {30'h0, cur_sel}, oh_idx(tv[i].exp_ena));
            end
            sb_check($sformatf("rr_uo[%0d]", i));
            prev_ena = tv[i].exp_ena;
        end

        // ---------------- datapath ----------------
        step();
        chk("dp_guard_ena", {28'h0, tile_ena}, 32'h0);
        step();
        chk("dp_tile1_ena", {28'h0, tile_ena}, 32'h2);
        ui_in = 8'h21;
        #1;
        chk("dp_tile_ui", tile_ui, 32'h0000_2100);
        tile_uo = 32'h4433_4211;
        sb_q.push_back(8'h42);
        step();
        sb_check("dp_uo_lag");
        step();
        step();
        step();
        chk("dp_guard2_ena", {28'h0, tile_ena}, 32'h0);
        chk("dp_guard2_tile_ui", tile_ui, 32'h0);
        chk("dp_guard2_uo", {24'h0, uo_out}, 32'h42);
        tile_uo = 32'h7777_7777;
        step();
        chk("dp_hold_uo", {24'h0, uo_out}, 32'h42);
        chk("dp_tile3_ena", {28'h0, tile_ena}, 32'h8);
        chk("dp_tile3_ss", {31'h0, slot_start}, 32'h1);

        // ---------------- mid-slot disable ----------------
        step();
        en_mask = 4'b0011;
        step();
        chk("dis_guard_ena", {28'h0, tile_ena}, 32'h0);
        step();
        chk("dis_next_ena", {28'h0, tile_ena}, 32'h1);
        chk("dis_next_sel", {30'h0, cur_sel}, 32'h0);
        chk("dis_next_ss", {31'h0, slot_start}, 32'h1);
        en_mask = 4'b0000;
        step();
        chk("clr_idle_ena", {28'h0, tile_ena}, 32'h0);
        step();
        chk("clr_idle_uo", {24'h0, uo_out}, 32'h0);

        // ---------------- manual mode ----------------
        mode    = 1'b1;
        sel_in  = 2'd2;
        en_mask = 4'b1111;
        step();
        chk("man_guard_ena", {28'h0, tile_ena}, 32'h0);
        step();
        chk("man_ena", {28'h0, tile_ena}, 32'h4);
        chk("man_ss", {31'h0, slot_start}, 32'h1);
        chk("man_sel", {30'h0, cur_sel}, 32'h2);
        for (int i = 0; i < 10; i++) begin
            step();
            chk($sformatf("man_hold_ena[%0d]", i), {28'h0, tile_ena}, 32'h4);
            chk($sformatf("man_hold_ss[%0d]", i), {31'h0, slot_start}, 32'h0);
        end
        sel_in  = 2'd3;
        en_mask = 4'b0111;
        for (int i = 0; i < 5; i++) begin
            step();
            chk($sformatf("man_dis_sel_ena[%0d]", i), {28'h0, tile_ena}, 32'h4);
        end
        mode    = 1'b0;
        en_mask = 4'b1111;
        for (int i = 0; i < 3; i++) begin
            step();
            chk($sformatf("resume_ena[%0d]", i), {28'h0, tile_ena}, 32'h4);
        end
        step();
        chk("resume_guard_ena", {28'h0, tile_ena}, 32'h0);
        step();
        chk("resume_tile3_ena", {28'h0, tile_ena}, 32'h8);
        chk("resume_tile3_ss", {31'h0, slot_start}, 32'h1);

        // ---------------- async reset mid-RUN ----------------
        mode   = 1'b1;
        sel_in = 2'd1;
        step();
        chk("hop_guard_ena", {28'h0, tile_ena}, 32'h0);
        step();
        chk("hop_tile1_ena", {28'h0, tile_ena}, 32'h2);
        tile_uo = 32'h5555_5555;
        step();
        chk("pre_rst_uo", {24'h0, uo_out}, 32'h55);
        #2 rst = 1'b1;
        #1;
        chk("async_rst_uo", {24'h0, uo_out}, 32'h0);
        chk("async_rst_ena", {28'h0, tile_ena}, 32'h0);
        chk("async_rst_sel", {30'h0, cur_sel}, 32'h0);
        chk("async_rst_ss", {31'h0, slot_start}, 32'h0);
        en_mask = 4'b0000;
        mode    = 1'b0;
        step();
        rst = 1'b0;
        step();
        step();
        step();
        chk("post_rst_idle_ena", {28'h0, tile_ena}, 32'h0);
        chk("post_rst_idle_uo", {24'h0, uo_out}, 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
